mul_sequencer: RTL
==================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter: N, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  in  1  request pulse; accepted only when busy=0.
REQ-005 SHALL have port: mla  in  1  accumulate select (MLA when 1, MUL when 0); sampled with start.
REQ-006 SHALL have port: set_flags  in  1  S-bit; sampled with start.
REQ-007 SHALL have port: a  in  N  multiplicand (Rm); sampled with start.
REQ-008 SHALL have port: b  in  N  multiplier (Rs); sampled with start.
REQ-009 SHALL have port: acc  in  N  accumulate addend (Rn); sampled with start.
REQ-010 SHALL have port: busy  out  1  high in MULT and DONE states.
REQ-011 SHALL have port: done  out  1  one-cycle pulse, result/flags valid.
REQ-012 SHALL have port: result  out  N  low N bits of a*b (+acc).
REQ-013 SHALL have port: flags  out  4  {V,C,Z,N} at bits [3:0] = {3,2,1,0}.
REQ-014 SHALL have port: flags_we  out  4  per-flag write enable, valid with done.

Function
REQ-015 SHALL implement FSM states IDLE, MULT, DONE.
REQ-016 IDLE: on start=1, capture mcand<=a, mplr<=b, prod<=(mla ? acc : 0), cnt<=0, latch set_flags; go to MULT.
REQ-017 MULT, each cycle: if mplr[0]=1 then prod<=prod+mcand via the adder sub-module, else prod unchanged; mcand<=mcand<<1; mplr<=mplr>>1; cnt<=cnt+1.
REQ-018 MULT exit to DONE when cnt=N-1 or shifted mplr (mplr>>1)=0 (early termination); else stay.
REQ-019 Latency: with start accepted in cycle T, done SHALL be high in cycle T+1+k, k=max(1, index of highest set bit of b +1); k ranges 1..N.
REQ-020 DONE: result<=prod, done=1 for exactly one cycle, then IDLE unconditionally.
REQ-021 Arithmetic SHALL be modulo 2^N; adder carry-out discarded.
REQ-022 flags[0]=result[N-1], flags[1]=(result==0); flags[3:2] SHALL be 0.
REQ-023 flags_we SHALL be 4'b0011 in DONE cycle when latched set_flags=1; 4'b0000 otherwise.
REQ-024 result and flags SHALL hold their value after done until the next DONE.
REQ-025 start while busy=1 (MULT or DONE) SHALL be ignored, with no effect on captured operands.
REQ-026 start in the cycle after DONE (IDLE) SHALL be accepted; back-to-back operations without gap cycles beyond DONE.
REQ-027 Changes on a, b, acc, mla, set_flags after acceptance SHALL not affect the running operation.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, flags=0, flags_we=0, internal regs=0.
REQ-029 Reset asserted mid-MULT or in DONE SHALL abort the operation with no done pulse; start in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-030 Shared package arm_alu_pkg SHALL hold flag bit indices (FLAG_N=0, FLAG_Z=1, FLAG_C=2, FLAG_V=3) and enum mul_state_t {IDLE, MULT, DONE}.
REQ-031 SHALL instantiate exactly one sub-module: adder #(.N(N)) performing prod+mcand; its FLAGS output unused.
REQ-032 Counter width SHALL be $clog2(N) bits.

Verification
REQ-033 a=7, b=6, acc=0, mla=0, set_flags=1, start at T -> done at T+4, result=42, flags=4'b0000, flags_we=4'b0011.
REQ-034 a=5, b=0, acc=100, mla=1 -> done at T+2, result=100, flags_we=0 when set_flags=0.
REQ-035 a=b=0xFFFFFFFF, mla=0 -> done at T+33, result=0x00000001; a=0x80000000, b=1 -> result=0x80000000, flags[0]=1 at T+2.
REQ-036 a=0, b=5, set_flags=1 -> result=0, flags[1]=1, done at T+4.
REQ-037 Second start pulsed during MULT with different operands -> ignored, first result correct; start the cycle after done -> accepted.
REQ-038 rst_n=0 during MULT cycle 10 of 32 -> next cycle busy=0, done=0, result=0, no done pulse until a new start.

Source files
------------

// File: rtl/arm_alu_pkg.sv
// Shared ARM ALU definitions: flag bit positions and the multiply sequencer states.
package arm_alu_pkg;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer_adder.sv
// N-bit adder with {V,C,Z,N} flags; the carry-out only reaches the C flag.
module adder
  import arm_alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic [3:0]   flags
);

  logic [N:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    sum   = full[N-1:0];
    flags = '0;
    flags[FLAG_N] = full[N-1];
    flags[FLAG_Z] = (full[N-1:0] == '0);
    flags[FLAG_C] = full[N];
    flags[FLAG_V] = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
  end

endmodule

// File: rtl/mul_sequencer.sv
// Shift-and-add MUL/MLA sequencer with early termination once the multiplier runs out of set bits.
module mul_sequencer
  import arm_alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mla,
  input  logic         set_flags,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] acc,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic [3:0]   flags_we
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mul_state_t    state, state_nxt;
  logic [N-1:0]  mcand, mplr, prod;
  logic [N-1:0]  sum, prod_nxt;
  logic [CW-1:0] cnt;
  logic          sf_q;
  logic          mult_last;
  logic [3:0]    flags_nxt;
  logic [3:0]    unused_add_flags;

  adder #(.N(N)) u_add (
    .a     (prod),
    .b     (mcand),
    .sum   (sum),
    .flags (unused_add_flags)
  );

  always_comb begin
    prod_nxt  = mplr[0] ? sum : prod;
    mult_last = (cnt == CNT_LAST) || ((mplr >> 1) == '0);
    flags_nxt = '0;
    flags_nxt[FLAG_N] = prod_nxt[N-1];
    flags_nxt[FLAG_Z] = (prod_nxt == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MULT;
      MULT:    if (mult_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    flags_we = '0;
    if (done && sf_q) flags_we = 4'b0011;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // result/flags load on the final MULT edge so they are already valid while done is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplr   <= '0;
      prod   <= '0;
      cnt    <= '0;
      sf_q   <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            mplr  <= b;
            prod  <= mla ? acc : '0;
            cnt   <= '0;
            sf_q  <= set_flags;
          end
        end
        MULT: begin
          prod  <= prod_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (mult_last) begin
            result <= prod_nxt;
            flags  <= flags_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
